// File: rtl/xgmii_delay_pkg.sv
// xgmii_delay_pkg: shared constants and state encoding for the XGMII delay line.
package xgmii_delay_pkg;
    localparam int AW   = 15;
    localparam int DW   = 34;
    localparam int DMIN = 8;
    // K: RAM write, the 2-cycle read and the output register sit after the input register,
    // so the read address trails the write address by D-K slots.
    localparam int K    = 4;
    typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;
endpackage

// File: rtl/blk_com_dpram_32768x34.sv
// blk_com_dpram_32768x34: simple dual-port RAM, write on port A, pipelined read on port B.
module blk_com_dpram_32768x34
    import xgmii_delay_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic          clka,
    input  logic          ena,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] dina,
    input  logic          clkb,
    input  logic          rstb,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] doutb
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] pipe_q [RD_LAT];

    always_ff @(posedge clka) begin
        if (ena && wea) mem[addra] <= dina;
    end

    always_ff @(posedge clkb or posedge rstb) begin
        if (rstb) begin
            pipe_q <= '{default: '0};
        end else if (enb) begin
            pipe_q[0] <= mem[addrb];
            for (int i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign doutb = pipe_q[RD_LAT-1];
endmodule

// File: rtl/xgmii_delay_ctrl.sv
// xgmii_delay_ctrl: programmable D-cycle delay line built on a DPRAM ring buffer.
module xgmii_delay_ctrl
    import xgmii_delay_pkg::*;
#(
    parameter int AW            = 15,
    parameter int DW            = 34,
    parameter int RD_LAT        = 2,
    parameter int DEFAULT_DELAY = 64,
    parameter int DMIN          = 8
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_din_vld,
    input  logic [DW-2:0] I_din,
    input  logic          I_cfg_update,
    input  logic [AW-1:0] I_delay_cfg,
    output logic          O_dout_vld,
    output logic [DW-2:0] O_dout,
    output logic          O_busy,
    output logic          O_cfg_err
);
    state_e        state_q, state_d;
    logic [AW-1:0] d_q, d_d, fill_q, fill_d, wr_q, rd_addr;
    logic [DW-1:0] in_q, out_q, ram_dout;
    logic          err_q, err_d, en;

    assign en      = state_q != IDLE;
    assign rd_addr = wr_q - (d_q - AW'(K));

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        fill_d  = fill_q + AW'(1);
        err_d   = err_q;
        if (state_q == FILL && fill_q == d_q - AW'(1)) state_d = RUN;
        if (I_cfg_update) begin
            if (I_delay_cfg >= AW'(DMIN)) begin
                state_d = FILL;
                d_d     = I_delay_cfg;
                err_d   = 1'b0;
                // the word accepted with the update is fill word 0, so counting resumes at 1
                fill_d  = AW'(1);
            end else begin
                state_d = IDLE;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q <= FILL;
            d_q     <= AW'(DEFAULT_DELAY);
            fill_q  <= '0;
            wr_q    <= '0;
            err_q   <= 1'b0;
            in_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            d_q     <= d_d;
            fill_q  <= fill_d;
            wr_q    <= wr_q + AW'(en);
            err_q   <= err_d;
            in_q    <= {I_din_vld, I_din};
            out_q   <= (state_d == RUN) ? ram_dout : '0;
        end
    end

    blk_com_dpram_32768x34 #(.RD_LAT(RD_LAT)) u_ram (
        .clka  (I_clk),
        .ena   (en),
        .wea   (1'b1),
        .addra (wr_q),
        .dina  (in_q),
        .clkb  (I_clk),
        .rstb  (~I_rst_n),
        .enb   (en),
        .addrb (rd_addr),
        .doutb (ram_dout)
    );

    assign O_dout_vld = out_q[DW-1];
    assign O_dout     = out_q[DW-2:0];
    assign O_busy     = state_q != RUN;
    assign O_cfg_err  = err_q;
endmodule

// File: tb/tb_xgmii_delay_ctrl.sv
// tb_xgmii_delay_ctrl: scoreboard bench for the XGMII delay line.
module tb_xgmii_delay_ctrl;
    localparam int NEVER = 1 << 30;

    logic        clk = 1'b0, rst_n = 1'b0, din_vld = 1'b0, cfg_update = 1'b0;
    logic [32:0] din = '0;
    logic [14:0] delay_cfg = '0;
    logic        dout_vld, busy, cfg_err;
    logic [32:0] dout;
    wire  [35:0] got = {dout_vld, dout, busy, cfg_err};

    typedef struct {int due; logic v; logic [32:0] d;} exp_t;
    exp_t sb[$];
    int   checks = 0, failures = 0, cyc = 0, run_from = 64, d_m = 64, seq = 0;
    logic err_m = 1'b0, idle_m = 1'b0;

    always #5 clk = ~clk;

    xgmii_delay_ctrl dut (
        .I_clk        (clk),
        .I_rst_n      (rst_n),
        .I_din_vld    (din_vld),
        .I_din        (din),
        .I_cfg_update (cfg_update),
        .I_delay_cfg  (delay_cfg),
        .O_dout_vld   (dout_vld),
        .O_dout       (dout),
        .O_busy       (busy),
        .O_cfg_err    (cfg_err)
    );

    task automatic model_reset();
        sb.delete();
        cyc = 0; d_m = 64; run_from = 64; err_m = 1'b0; idle_m = 1'b0;
    endtask

    // Expected {vld, dout, busy, err} for the current cycle; pops the scoreboard in RUN.
    task automatic get_exp(output logic [35:0] w);
        exp_t e;
        logic eb;
        eb = cyc < run_from;
        w  = {1'b0, 33'd0, eb, err_m};
        if (!eb) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                w[35:2] = {e.v, e.d};
            end else begin
                w[35:2] = 'x;
            end
        end
    endtask

    // Drive one cycle of stimulus, update the reference model, advance to the next sample point.
    task automatic drive(input logic v, input logic [32:0] d, input logic upd, input int cfg);
        din_vld = v; din = d; cfg_update = upd; delay_cfg = 15'(cfg);
        if (upd && cfg >= 8) begin
            sb.delete(); d_m = cfg; err_m = 1'b0; idle_m = 1'b0; run_from = cyc + cfg;
        end else if (upd) begin
            sb.delete(); err_m = 1'b1; idle_m = 1'b1; run_from = NEVER;
        end
        if (!idle_m) sb.push_back('{cyc + d_m, v, d});
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (got !== {1'b0, 33'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", got, {1'b0, 33'd0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_ramp();
        logic [35:0] want;
        for (int i = 0; i < 200; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL ramp cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (cyc == 63 || cyc == 64) begin
                checks++;
                if (busy !== (cyc == 63) || dout !== 33'd0 || dout_vld !== (cyc == 64)) begin
                    failures++;
                    $display("FAIL ramp_edge cyc=%0d busy=%b dout=%h vld=%b", cyc, busy, dout, dout_vld);
                end
            end
            drive(1'b1, 33'(seq), 1'b0, 0);
            seq++;
        end
    endtask

    task automatic test_reconfig();
        logic [35:0] want;
        int u = NEVER, w_u = 0;
        for (int i = 0; i < 1100; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reconfig cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (cyc == u + 999 || cyc == u + 1000) begin
                checks++;
                if (busy !== (cyc == u + 999) || dout !== ((cyc == u + 999) ? 33'd0 : 33'(w_u))) begin
                    failures++;
                    $display("FAIL reconfig_first cyc=%0d busy=%b dout=%h want_word=%h", cyc, busy, dout, w_u);
                end
            end
            if (i == 5) begin u = cyc; w_u = seq; end
            drive(1'b1, 33'(seq), i == 5, 1000);
            seq++;
        end
    endtask

    task automatic test_illegal();
        logic [35:0] want;
        int u8 = NEVER, w8 = 0;
        for (int i = 0; i < 80; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL illegal cyc=%0d got=%h want=%h", cyc, got, want);
            end
            if (i == 4 || i == 31) begin
                checks++;
                if (cfg_err !== (i == 4) || busy !== 1'b1 || dout !== 33'd0) begin
                    failures++;
                    $display("FAIL cfg_err i=%0d err=%b busy=%b dout=%h", i, cfg_err, busy, dout);
                end
            end
            if (cyc == u8 + 8) begin
                checks++;
                if (dout !== 33'(w8) || dout_vld !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL delay8 got=%h want=%h busy=%b", dout, 33'(w8), busy);
                end
            end
            if (i == 30) begin u8 = cyc; w8 = seq; end
            drive(1'b1, 33'(seq), i == 3 || i == 30, (i == 3) ? 5 : 8);
            seq++;
        end
    endtask

    task automatic test_back_to_back();
        logic [35:0] want;
        for (int i = 0; i < 60; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, got, want);
            end
            drive(1'b1, 33'(seq), i == 0 || i == 10 || i == 11, (i == 0) ? 20 : (i == 10) ? 12 : 9);
            seq++;
        end
    endtask

    task automatic test_sparse();
        logic [35:0] want;
        for (int i = 0; i < 100; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL sparse cyc=%0d got=%h want=%h", cyc, got, want);
            end
            drive(i % 3 == 0, 33'({$urandom, $urandom}), i == 0, 16);
        end
    endtask

    task automatic test_wrap();
        logic [35:0] want;
        for (int i = 0; i < 32767 + 8000; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL wrap cyc=%0d got=%h want=%h", cyc, got, want);
            end
            drive(1'($urandom), 33'({$urandom, $urandom}), i == 0, 32767);
        end
    endtask

    task automatic test_reset_mid();
        logic [35:0] want;
        for (int i = 0; i < 260; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, got, want);
            end
            drive(1'b1, 33'(seq), i == 0, 200);
            seq++;
        end
        checks++;
        if (dout_vld !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_run vld=%b busy=%b", dout_vld, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (got !== {1'b0, 33'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", got, {1'b0, 33'd0, 1'b1, 1'b0});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 100; i++) begin
            get_exp(want);
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, got, want);
            end
            drive(1'b1, 33'h1_0000_0000 | 33'(i), 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_reconfig();
        test_illegal();
        test_back_to_back();
        test_sparse();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
